vmem_update_unit: RTL and testbench
===================================

# vmem_update_unit

Downstream writeback stage for the SNN processing element. Consumes the per-neuron result stream from the PE (9-bit conv result {vmem, spike} or 8-bit pooling result), applies the membrane reset rule, and stores the updated potential in a local membrane buffer. It packs output spikes into 16-bit words for the next layer and provides a registered read port that feeds stored potentials back to the PE `vmem` input on the next timestep.

## Interface
Parameters:
- NUM_NEURONS, 64, neurons per layer tile; depth of the membrane buffer (≥1).
- SPIKE_W, 16, bits per packed spike word.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a timestep (honoured only in IDLE).
- clear_mem  in  1  sampled with `start`; 1 zeroes every buffer entry.
- mode  in  1  0 = convolution, 1 = pooling; sampled at `start`, held for the timestep.
- reset_sub  in  1  0 = reset-to-zero, 1 = reset-by-subtraction; sampled at `start`.
- vth  in  8  threshold, unsigned; sampled at `start`.
- res_valid  in  1  PE result valid.
- res_ready  out  1  block accepts a result.
- conv_result  in  9  {vmem[7:0], spike}.
- ap_result  in  8  pooling sum.
- vmem_rd_addr  in  clog2(NUM_NEURONS)  read address.
- vmem_rd_data  out  8  registered read data.
- spike_word  out  SPIKE_W  packed spikes; bit i = neuron word_idx*SPIKE_W+i.
- spike_word_idx  out  clog2(ceil(NUM_NEURONS/SPIKE_W))  word index.
- spike_valid  out  1  word available.
- spike_ready  in  1  consumer takes word.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at timestep end.

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> FLUSH after result NUM_NEURONS-1 accepted; FLUSH -> DONE when no word pending; DONE -> IDLE unconditionally (asserts `done`).
- On `start`: neuron counter, bit counter and word index cleared; if clear_mem, all entries zeroed in the same cycle.
- Accept = res_valid && res_ready; neuron n = accept count (results arrive in order 0..N-1).
- Conv: v = conv_result[8:1], s = conv_result[0]. s=0: store v. s=1: store reset_sub ? v−vth : 0; if v ≤ vth with s=1, store 0 (no underflow). Spike bit = s.
- Pool: store ap_result; spike bit = (ap_result ≠ 0).
- Spike bits shift into packer at bit position n mod SPIKE_W. On SPIKE_W-th bit, or on the last neuron, the word moves to the output register with spike_valid=1; unfilled high bits are 0.
- res_ready = (state==RUN) && !(spike_valid && !spike_ready).
- Word leaves on spike_valid && spike_ready; a new word may load in that same cycle.
- Results while not in RUN are ignored (res_ready=0); `start` outside IDLE is ignored.

## Timing
- Reset values: res_ready 0, vmem_rd_data 0, spike_word 0, spike_word_idx 0, spike_valid 0, busy 0, done 0, all buffer entries 0, state IDLE.
- Buffer write lands on the clock edge of accept; vmem_rd_data valid one cycle after vmem_rd_addr.
- Read and write to the same address in the same cycle: read returns the old value.
- Final word: spike_valid rises the cycle after the last accept; `done` pulses the cycle after that word is taken (minimum 2 cycles after the last accept).
- Throughput: one result per cycle while spike_ready is held 1.
- nrst mid-timestep: immediate return to IDLE, buffer zeroed, pending word dropped.

## Structure
- Shared package `snn_pkg`: state enum (IDLE, RUN, FLUSH, DONE), the 9-bit conv result field layout, and the default SPIKE_W constant.
- One natural sub-module, `spike_packer`: shift/fill logic, output register and valid/ready handling. The membrane buffer and reset arithmetic stay in the top level.

## Test plan
- Reset-to-zero: vth=50, conv results {60,1},{30,0} to neurons 0,1 -> buffer[0]=0, buffer[1]=30; word bits0..1 = 2'b01.
- Subtraction: reset_sub=1, vth=50, {60,1} -> buffer[0]=10; illegal {40,1} -> 0.
- Packing with NUM_NEURONS=20: alternating spikes -> word0=16'h5555 (idx 0), word1=16'h0005 (idx 1, high bits zero), then `done`.
- Backpressure: hold spike_ready=0 after word0 -> res_ready drops; no result lost; release -> stream resumes and all 20 entries are correct.
- Pool: ap_result sequence 0,3,0,1 -> buffer holds 0,3,0,1; spike bits 4'b1010.
- Mid-run reset plus clear_mem: assert nrst after 7 accepts -> all outputs are 0; restart with clear_mem=1 -> every read returns 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN writeback path: FSM encoding, conv result layout and
// the reset rule applied to a membrane potential after a spike.
package snn_pkg;

  localparam int unsigned SpikeWDefault = 16;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StFlush = 2'd2;
  localparam state_t StDone  = 2'd3;

  typedef struct packed {
    logic [7:0] vmem;
    logic       spike;
  } conv_result_t;

  // Subtractive reset saturates at zero rather than wrapping.
  function automatic logic [7:0] apply_reset(input logic [7:0] v, input logic s,
                                             input logic sub, input logic [7:0] vth);
    if (!s) begin
      return v;
    end else if (sub && (v > vth)) begin
      return v - vth;
    end else begin
      return 8'd0;
    end
  endfunction

endpackage

// File: rtl/spike_packer.sv
// Collects one spike bit per accepted neuron into SPIKE_W-bit words and presents each
// word on a valid/ready output register.
module spike_packer
  import snn_pkg::*;
#(
  parameter int unsigned SPIKE_W    = SpikeWDefault,
  parameter int unsigned WORD_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  bit_last,
  output logic [SPIKE_W-1:0]    spike_word,
  output logic [WORD_IDX_W-1:0] spike_word_idx,
  output logic                  spike_valid,
  input  logic                  spike_ready
);

  localparam int unsigned BitW = $clog2(SPIKE_W);

  logic [SPIKE_W-1:0]    acc_q, acc_d;
  logic [BitW-1:0]       bcnt_q;
  logic [WORD_IDX_W-1:0] widx_q;
  logic [SPIKE_W-1:0]    word_q;
  logic [WORD_IDX_W-1:0] idx_q;
  logic                  valid_q;
  logic                  full;

  always_comb begin
    acc_d = acc_q | (SPIKE_W'(bit_in) << bcnt_q);
    full  = bit_valid && ((bcnt_q == BitW'(SPIKE_W - 1)) || bit_last);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q   <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (clear) begin
        acc_q  <= '0;
        bcnt_q <= '0;
        widx_q <= '0;
      end else if (bit_valid) begin
        if (full) begin
          acc_q  <= '0;
          bcnt_q <= '0;
          widx_q <= widx_q + 1'b1;
        end else begin
          acc_q  <= acc_d;
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
      // Upstream only feeds a bit when the output register is empty or draining now.
      if (full) begin
        word_q  <= acc_d;
        idx_q   <= widx_q;
        valid_q <= 1'b1;
      end else if (spike_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign spike_word     = word_q;
  assign spike_word_idx = idx_q;
  assign spike_valid    = valid_q;

endmodule

// File: rtl/vmem_update_unit.sv
// Writeback stage: applies the membrane reset rule to each PE result, stores it in the
// membrane buffer, packs spikes for the next layer and serves registered reads.
module vmem_update_unit
  import snn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 64,
  parameter int unsigned SPIKE_W     = SpikeWDefault,
  localparam int unsigned AddrW      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int unsigned NumWords   = (NUM_NEURONS + SPIKE_W - 1) / SPIKE_W,
  localparam int unsigned WidxW      = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               clear_mem,
  input  logic               mode,
  input  logic               reset_sub,
  input  logic [7:0]         vth,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [8:0]         conv_result,
  input  logic [7:0]         ap_result,
  input  logic [AddrW-1:0]   vmem_rd_addr,
  output logic [7:0]         vmem_rd_data,
  output logic [SPIKE_W-1:0] spike_word,
  output logic [WidxW-1:0]   spike_word_idx,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic               busy,
  output logic               done
);

  state_t           state_q, state_d;
  logic             mode_q, rsub_q;
  logic [7:0]       vth_q;
  logic [AddrW-1:0] ncnt_q;
  logic [7:0]       mem_q [NUM_NEURONS];
  logic [7:0]       rd_q;

  conv_result_t cres;
  logic         accept, last, start_ok, spike_bit;
  logic [7:0]   wr_data;

  assign cres      = conv_result_t'(conv_result);
  assign start_ok  = start && (state_q == StIdle);
  assign res_ready = (state_q == StRun) && !(spike_valid && !spike_ready);
  assign accept    = res_valid && res_ready;
  assign last      = (ncnt_q == AddrW'(NUM_NEURONS - 1));

  always_comb begin
    if (mode_q) begin
      wr_data   = ap_result;
      spike_bit = |ap_result;
    end else begin
      wr_data   = apply_reset(cres.vmem, cres.spike, rsub_q, vth_q);
      spike_bit = cres.spike;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && last) state_d = StFlush;
      // Leave as soon as the final word is gone or is being taken this cycle.
      StFlush: if (!spike_valid || spike_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      rsub_q  <= 1'b0;
      vth_q   <= '0;
      ncnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q <= mode;
        rsub_q <= reset_sub;
        vth_q  <= vth;
        ncnt_q <= '0;
      end else if (accept) begin
        ncnt_q <= ncnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (start_ok && clear_mem) begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      end else if (accept) begin
        mem_q[ncnt_q] <= wr_data;
      end
      rd_q <= mem_q[vmem_rd_addr];
    end
  end

  spike_packer #(
    .SPIKE_W    (SPIKE_W),
    .WORD_IDX_W (WidxW)
  ) u_spike_packer (
    .clk            (clk),
    .nrst           (nrst),
    .clear          (start_ok),
    .bit_valid      (accept),
    .bit_in         (spike_bit),
    .bit_last       (last),
    .spike_word     (spike_word),
    .spike_word_idx (spike_word_idx),
    .spike_valid    (spike_valid),
    .spike_ready    (spike_ready)
  );

  assign vmem_rd_data = rd_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_vmem_update_unit.sv
// Directed bench for vmem_update_unit with a 20-neuron tile: table-driven timesteps plus
// hand-written backpressure, read-during-write and reset sequences.
module tb_vmem_update_unit;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        nrst, start, clear_mem, mode, reset_sub;
  logic [7:0]  vth;
  logic        res_valid, res_ready;
  logic [8:0]  conv_result;
  logic [7:0]  ap_result;
  logic [4:0]  vmem_rd_addr;
  logic [7:0]  vmem_rd_data;
  logic [15:0] spike_word;
  logic [0:0]  spike_word_idx;
  logic        spike_valid, spike_ready, busy, done;

  vmem_update_unit #(
    .NUM_NEURONS (N),
    .SPIKE_W     (16)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start          (start),
    .clear_mem      (clear_mem),
    .mode           (mode),
    .reset_sub      (reset_sub),
    .vth            (vth),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .conv_result    (conv_result),
    .ap_result      (ap_result),
    .vmem_rd_addr   (vmem_rd_addr),
    .vmem_rd_data   (vmem_rd_data),
    .spike_word     (spike_word),
    .spike_word_idx (spike_word_idx),
    .spike_valid    (spike_valid),
    .spike_ready    (spike_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] conv;
    logic [7:0] ap;
    logic [7:0] exp_v;
    logic       exp_s;
  } vec_t;

  vec_t        vecs [N];
  logic [15:0] words [$];
  int          widxs [$];
  int          checks = 0;
  int          errors = 0;
  int          stalls;

  always @(negedge clk) begin
    if (spike_valid && spike_ready) begin
      words.push_back(spike_word);
      widxs.push_back(int'(spike_word_idx));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 spike_ready = v;
  endtask

  task automatic do_start(input logic clr, input logic m, input logic rs, input logic [7:0] th);
    start = 1'b1; clear_mem = clr; mode = m; reset_sub = rs; vth = th;
    @(negedge clk);
    start = 1'b0; clear_mem = 1'b0;
  endtask

  task automatic send(input logic [8:0] c, input logic [7:0] a);
    conv_result = c; ap_result = a; res_valid = 1'b1;
    for (int w = 0; w < 50 && !res_ready; w++) begin
      @(negedge clk);
      stalls++;
    end
    check("accept_wait", res_ready, 1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic run_vecs(input string tag, input int raw_idx, input logic [7:0] raw_old);
    logic [15:0] exp_w;
    words.delete(); widxs.delete(); stalls = 0;
    if (raw_idx >= 0) vmem_rd_addr = 5'(raw_idx);
    for (int i = 0; i < N; i++) begin
      send(vecs[i].conv, vecs[i].ap);
      if (i == raw_idx) begin
        check({tag, "_raw_old"}, vmem_rd_data, raw_old);
        @(negedge clk);
        check({tag, "_raw_new"}, vmem_rd_data, vecs[i].exp_v);
      end
    end
    check({tag, "_final_valid"}, spike_valid, 1);
    check({tag, "_done_early"}, done, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_nwords"}, words.size(), 2);
    for (int w = 0; w < 2; w++) begin
      exp_w = '0;
      for (int b = 0; b < 16; b++) if (w * 16 + b < N) exp_w[b] = vecs[w * 16 + b].exp_s;
      if (words.size() > w) begin
        check($sformatf("%s_word%0d", tag, w), words[w], exp_w);
        check($sformatf("%s_idx%0d", tag, w), widxs[w], w);
      end
    end
    for (int i = 0; i < N; i++) begin
      vmem_rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("%s_v%0d", tag, i), vmem_rd_data, vecs[i].exp_v);
    end
  endtask

  task automatic fill_conv_rtz();
    for (int i = 0; i < N; i++) vecs[i] = '{{8'(i * 3), 1'b0}, 8'd0, 8'(i * 3), 1'b0};
    vecs[0] = '{{8'd60, 1'b1}, 8'd0, 8'd0, 1'b1};
    vecs[1] = '{{8'd30, 1'b0}, 8'd0, 8'd30, 1'b0};
    vecs[2] = '{{8'd50, 1'b1}, 8'd0, 8'd0, 1'b1};
  endtask

  task automatic fill_alt(input logic [7:0] even_v);
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) vecs[i] = '{{8'd20, 1'b1}, 8'd0, even_v, 1'b1};
      else            vecs[i] = '{{8'd20, 1'b0}, 8'd0, 8'd20, 1'b0};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; start = 1'b0; clear_mem = 1'b0; mode = 1'b0; reset_sub = 1'b0;
    vth = '0; res_valid = 1'b0; conv_result = '0; ap_result = '0; vmem_rd_addr = '0;
    spike_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_res_ready", res_ready, 0);
    check("rst_rd_data", vmem_rd_data, 0);
    check("rst_word", spike_word, 0);
    check("rst_valid", spike_valid, 0);
    check("rst_busy_done", {busy, done}, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Reset-to-zero
    fill_conv_rtz();
    do_start(1'b0, 1'b0, 1'b0, 8'd50);
    run_vecs("rtz", -1, 8'd0);

    // Reset-by-subtraction, with read-during-write on address 1 (old value 30)
    for (int i = 5; i < N; i++) vecs[i] = '{{8'd100, 1'b0}, 8'd0, 8'd100, 1'b0};
    vecs[0] = '{{8'd60, 1'b1}, 8'd0, 8'd10, 1'b1};
    vecs[1] = '{{8'd40, 1'b1}, 8'd0, 8'd0, 1'b1};
    vecs[2] = '{{8'd50, 1'b1}, 8'd0, 8'd0, 1'b1};
    vecs[3] = '{{8'd255, 1'b1}, 8'd0, 8'd205, 1'b1};
    vecs[4] = '{{8'd7, 1'b0}, 8'd0, 8'd7, 1'b0};
    do_start(1'b0, 1'b0, 1'b1, 8'd50);
    run_vecs("sub", 1, 8'd30);

    // Alternating spikes: 16'h5555 then 16'h0005, full throughput
    fill_alt(8'd0);
    do_start(1'b0, 1'b0, 1'b0, 8'd10);
    run_vecs("pack", -1, 8'd0);
    check("pack_stalls", stalls, 0);

    // Backpressure after word0
    fill_alt(8'd15);
    set_ready(1'b0);
    @(negedge clk);
    do_start(1'b0, 1'b0, 1'b1, 8'd5);
    fork
      run_vecs("bp", -1, 8'd0);
      begin
        for (int w = 0; w < 100 && !spike_valid; w++) @(negedge clk);
        check("bp_word_seen", spike_valid, 1);
        repeat (3) @(negedge clk);
        check("bp_ready_low", res_ready, 0);
        check("bp_hold_word", spike_word, 16'h5555);
        set_ready(1'b1);
      end
    join
    check("bp_stalled", stalls >= 3, 1);

    // Pooling
    for (int i = 4; i < N; i++) vecs[i] = '{9'h1FF, 8'(i), 8'(i), 1'b1};
    vecs[0] = '{9'h1FF, 8'd0, 8'd0, 1'b0};
    vecs[1] = '{9'h1FF, 8'd3, 8'd3, 1'b1};
    vecs[2] = '{9'h1FF, 8'd0, 8'd0, 1'b0};
    vecs[3] = '{9'h1FF, 8'd1, 8'd1, 1'b1};
    do_start(1'b0, 1'b1, 1'b0, 8'd0);
    run_vecs("pool", -1, 8'd0);

    // Reset after 7 accepts
    do_start(1'b0, 1'b0, 1'b0, 8'd50);
    for (int i = 0; i < 7; i++) send({8'(i + 11), 1'b0}, 8'd0);
    nrst = 1'b0;
    #1;
    check("mid_res_ready", res_ready, 0);
    check("mid_rd_data", vmem_rd_data, 0);
    check("mid_word", spike_word, 0);
    check("mid_idx", spike_word_idx, 0);
    check("mid_valid", spike_valid, 0);
    check("mid_busy_done", {busy, done}, 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vmem_rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("mid_v%0d", i), vmem_rd_data, 0);
    end

    // clear_mem wipes a populated buffer
    do_start(1'b0, 1'b1, 1'b0, 8'd0);
    run_vecs("pool2", -1, 8'd0);
    do_start(1'b1, 1'b0, 1'b0, 8'd50);
    for (int i = 0; i < N; i++) begin
      vmem_rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("clr_v%0d", i), vmem_rd_data, 0);
    end
    fill_conv_rtz();
    run_vecs("rerun", -1, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
